// File: rtl/serial_cmd_engine.sv
// UART command engine: opcode/argument decode, control registers,
// PLL phase-step / pulse sequencing and histogram readout over TX.
module serial_cmd_engine #(
    parameter int NHIST      = 4,
    parameter int HIST_W     = 32,
    parameter int MAX_ARGS   = 4,
    parameter int FW_VERSION = 12,
    parameter int RX_TIMEOUT = 50000000,
    parameter int SCAN_HALF  = 16,
    parameter int PULSE_LEN  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_ready,
    input  logic [7:0]              rx_data,
    input  logic                    tx_busy,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic [NHIST*HIST_W-1:0] hist,
    output logic                    hist_reset,
    output logic [7:0]              dead_ticks,
    output logic [7:0]              firing_ticks,
    output logic                    enable_outputs,
    output logic [2:0]              mode_flags,
    output logic [2:0]              phase_offset,
    output logic [2:0]              phase_cnt_sel,
    output logic                    phase_updown,
    output logic                    phase_step,
    output logic                    scan_clk,
    output logic                    clk_switch,
    output logic                    pll_areset,
    output logic [7:0]              err_count
);

    localparam int HW = NHIST * HIST_W;
    localparam int NB = HW / 8;
    localparam int CW = $clog2(NB + 1);
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam int IW = $clog2(MAX_ARGS + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam int SW = $clog2(SCAN_HALF + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARGS    = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_TX_WAIT = 3'd3;
    localparam logic [2:0] S_TX_GAP  = 3'd4;
    localparam logic [2:0] S_PHASE   = 3'd5;
    localparam logic [2:0] S_PULSE   = 3'd6;

    function automatic logic [IW-1:0] nargs_of(input logic [7:0] op);
        case (op)
            8'd1, 8'd2, 8'd7: nargs_of = IW'(1);
            8'd5:             nargs_of = IW'(2);
            default:          nargs_of = '0;
        endcase
    endfunction

    logic [2:0]                state_q, state_d;
    logic [7:0]                op_q, op_d;
    logic [MAX_ARGS-1:0][7:0]  args_q, args_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic [HW-1:0]             buf_q, buf_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      txs_q, txs_d;
    logic [7:0]                txd_q, txd_d;
    logic [7:0]                dead_q, dead_d;
    logic [7:0]                fire_q, fire_d;
    logic                      en_q, en_d;
    logic [2:0]                mode_q, mode_d;
    logic [2:0]                off_q, off_d;
    logic [2:0]                sel_q, sel_d;
    logic                      ud_q, ud_d;
    logic                      step_q, step_d;
    logic                      scan_q, scan_d;
    logic                      cs_q, cs_d;
    logic                      ar_q, ar_d;
    logic [7:0]                err_q, err_d;
    logic [7:0]                steps_q, steps_d;
    logic [SW-1:0]             half_q, half_d;
    logic [2:0]                tog_q, tog_d;
    logic [PW-1:0]             pcnt_q, pcnt_d;
    logic                      unused_args;

    assign unused_args = ^args_q;

    // Next-state and register-update logic for the command sequencer
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        args_d  = args_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        txs_d   = 1'b0;
        txd_d   = txd_q;
        dead_d  = dead_q;
        fire_d  = fire_q;
        en_d    = en_q;
        mode_d  = mode_q;
        off_d   = off_q;
        sel_d   = sel_q;
        ud_d    = ud_q;
        step_d  = step_q;
        scan_d  = scan_q;
        cs_d    = cs_q;
        ar_d    = ar_q;
        err_d   = err_q;
        steps_d = steps_q;
        half_d  = half_q;
        tog_d   = tog_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            S_IDLE: begin
                if (rx_ready) begin
                    op_d    = rx_data;
                    idx_d   = '0;
                    timer_d = '0;
                    if (nargs_of(rx_data) != '0) state_d = S_ARGS;
                    else                         state_d = S_EXEC;
                end
            end
            S_ARGS: begin
                if (rx_ready) begin
                    for (int i = 0; i < MAX_ARGS; i++)
                        if (idx_q == IW'(i)) args_d[i] = rx_data;
                    idx_d   = idx_q + IW'(1);
                    timer_d = '0;
                    if (idx_q == nargs_of(op_q) - IW'(1))
                        state_d = S_EXEC;
                end else if (timer_q == TW'(RX_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                case (op_q)
                    8'd0: begin
                        buf_d      = '0;
                        buf_d[7:0] = 8'(FW_VERSION);
                        cnt_d      = CW'(1);
                        state_d    = S_TX_WAIT;
                    end
                    8'd1: dead_d = args_q[0];
                    8'd2: fire_d = args_q[0];
                    8'd3: en_d = ~en_q;
                    8'd4: begin
                        cs_d    = 1'b1;
                        pcnt_d  = '0;
                        state_d = S_PULSE;
                    end
                    8'd5: begin
                        sel_d = args_q[0][2:0];
                        ud_d  = args_q[0][7];
                        if (args_q[1] != 8'd0) begin
                            steps_d = args_q[1];
                            half_d  = '0;
                            tog_d   = '0;
                            step_d  = 1'b1;
                            scan_d  = 1'b0;
                            state_d = S_PHASE;
                        end
                    end
                    8'd6: off_d = off_q + 3'd1;
                    8'd7: mode_d = args_q[0][2:0];
                    8'd10: begin
                        buf_d   = hist;
                        cnt_d   = CW'(NB);
                        state_d = S_TX_WAIT;
                    end
                    8'd13: begin
                        ar_d    = 1'b1;
                        pcnt_d  = '0;
                        state_d = S_PULSE;
                    end
                    8'd14: begin
                        buf_d      = '0;
                        buf_d[7:0] = err_q;
                        cnt_d      = CW'(1);
                        err_d      = 8'd0;
                        state_d    = S_TX_WAIT;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_TX_WAIT: begin
                if (!tx_busy) begin
                    txs_d   = 1'b1;
                    txd_d   = buf_q[7:0];
                    buf_d   = buf_q >> 8;
                    cnt_d   = cnt_q - CW'(1);
                    state_d = S_TX_GAP;
                end
            end
            S_TX_GAP: begin
                if (cnt_q != '0) state_d = S_TX_WAIT;
                else             state_d = S_IDLE;
            end
            S_PHASE: begin
                if (half_q == SW'(SCAN_HALF - 1)) begin
                    half_d = '0;
                    scan_d = ~scan_q;
                    tog_d  = tog_q + 3'd1;
                    if (tog_q == 3'd5) step_d = 1'b0;
                    if (tog_q == 3'd7) begin
                        steps_d = steps_q - 8'd1;
                        if (steps_q == 8'd1) state_d = S_IDLE;
                        else                 step_d  = 1'b1;
                    end
                end else begin
                    half_d = half_q + SW'(1);
                end
            end
            S_PULSE: begin
                if (pcnt_q == PW'(PULSE_LEN - 1)) begin
                    cs_d    = 1'b0;
                    ar_d    = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any sequence and restores defaults
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            args_q  <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            txs_q   <= 1'b0;
            txd_q   <= '0;
            dead_q  <= 8'd10;
            fire_q  <= 8'd9;
            en_q    <= 1'b0;
            mode_q  <= 3'b101;
            off_q   <= '0;
            sel_q   <= '0;
            ud_q    <= 1'b1;
            step_q  <= 1'b0;
            scan_q  <= 1'b0;
            cs_q    <= 1'b0;
            ar_q    <= 1'b0;
            err_q   <= '0;
            steps_q <= '0;
            half_q  <= '0;
            tog_q   <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            args_q  <= args_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            txs_q   <= txs_d;
            txd_q   <= txd_d;
            dead_q  <= dead_d;
            fire_q  <= fire_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            off_q   <= off_d;
            sel_q   <= sel_d;
            ud_q    <= ud_d;
            step_q  <= step_d;
            scan_q  <= scan_d;
            cs_q    <= cs_d;
            ar_q    <= ar_d;
            err_q   <= err_d;
            steps_q <= steps_d;
            half_q  <= half_d;
            tog_q   <= tog_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // Histogram clear coincides with the snapshot edge
    assign hist_reset     = (state_q == S_EXEC) && (op_q == 8'd10);
    assign tx_start       = txs_q;
    assign tx_data        = txd_q;
    assign dead_ticks     = dead_q;
    assign firing_ticks   = fire_q;
    assign enable_outputs = en_q;
    assign mode_flags     = mode_q;
    assign phase_offset   = off_q;
    assign phase_cnt_sel  = sel_q;
    assign phase_updown   = ud_q;
    assign phase_step     = step_q;
    assign scan_clk       = scan_q;
    assign clk_switch     = cs_q;
    assign pll_areset     = ar_q;
    assign err_count      = err_q;

endmodule

// File: tb/tb_serial_cmd_engine.sv
// Randomised scoreboard bench for serial_cmd_engine.
// TX bytes are queued at issue time and popped by an output monitor.
module tb_serial_cmd_engine;

    localparam int RXTO = 20;
    localparam int SH   = 16;
    localparam int PL   = 8;
    localparam int FW   = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_ready = 1'b0;
    logic [7:0]   rx_data = 8'd0;
    logic         tx_busy;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic [127:0] hist = '0;
    logic         hist_reset;
    logic [7:0]   dead_ticks, firing_ticks, err_count;
    logic         enable_outputs, phase_updown, phase_step;
    logic [2:0]   mode_flags, phase_offset, phase_cnt_sel;
    logic         scan_clk, clk_switch, pll_areset;

    serial_cmd_engine #(
        .RX_TIMEOUT(RXTO), .SCAN_HALF(SH), .PULSE_LEN(PL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .hist(hist), .hist_reset(hist_reset),
        .dead_ticks(dead_ticks), .firing_ticks(firing_ticks),
        .enable_outputs(enable_outputs), .mode_flags(mode_flags),
        .phase_offset(phase_offset), .phase_cnt_sel(phase_cnt_sel),
        .phase_updown(phase_updown), .phase_step(phase_step),
        .scan_clk(scan_clk), .clk_switch(clk_switch),
        .pll_areset(pll_areset), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int errs = 0;
    logic [7:0] exp_tx[$];
    int popped = 0;
    int hr_cnt = 0, cs_cnt = 0, ar_cnt = 0;
    int tog_total = 0, step_rises = 0;
    logic scan_prev = 1'b0, step_prev = 1'b0;
    logic force_busy = 1'b0;
    int busy_cnt = 0;

    int m_dead, m_fire, m_en, m_mode, m_off, m_sel, m_ud, m_err;

    assign tx_busy = (busy_cnt != 0) || force_busy;

    // UART TX model: busy for a random time after every start
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_cnt <= 0;
        else if (tx_start) busy_cnt <= $urandom_range(2, 12);
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic check(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard and counts strobes/toggles
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_start) begin
                if (force_busy) begin
                    vec++; errs++;
                    $display("FAIL tx_while_busy: tx_start=1 required 0");
                end
                if (exp_tx.size() == 0) begin
                    vec++; errs++;
                    $display("FAIL tx_unexpected: byte %0d, none queued",
                             tx_data);
                end else begin
                    check("tx_byte", int'(tx_data), int'(exp_tx.pop_front()));
                end
                popped++;
            end
            if (hist_reset) hr_cnt++;
            if (clk_switch) cs_cnt++;
            if (pll_areset) ar_cnt++;
            if (scan_clk != scan_prev) tog_total++;
            if (step_prev && !phase_step)
                check("step_fall_toggle", tog_total % 8, 6);
            if (!step_prev && phase_step) step_rises++;
            scan_prev <= scan_clk;
            step_prev <= phase_step;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_dead = 10; m_fire = 9; m_en = 0; m_mode = 5;
        m_off = 0; m_sel = 0; m_ud = 1; m_err = 0;
    endtask

    function automatic int nargs(input logic [7:0] op);
        if (op == 1 || op == 2 || op == 7) return 1;
        if (op == 5) return 2;
        return 0;
    endfunction

    function automatic bit is_valid(input logic [7:0] op);
        return op <= 7 || op == 10 || op == 13 || op == 14;
    endfunction

    task automatic check_regs();
        check("dead_ticks", int'(dead_ticks), m_dead);
        check("firing_ticks", int'(firing_ticks), m_fire);
        check("enable_outputs", int'(enable_outputs), m_en);
        check("mode_flags", int'(mode_flags), m_mode);
        check("phase_offset", int'(phase_offset), m_off);
        check("phase_cnt_sel", int'(phase_cnt_sel), m_sel);
        check("phase_updown", int'(phase_updown), m_ud);
        check("err_count", int'(err_count), m_err);
        check("idle_strobes",
              int'({tx_start, hist_reset, phase_step, scan_clk,
                    clk_switch, pll_areset}), 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_ready = 1'b1;
        rx_data  = b;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic drain(input int extra);
        int n;
        n = 0;
        while (exp_tx.size() != 0 && n < 5000) begin
            tick();
            n++;
        end
        if (exp_tx.size() != 0) begin
            vec++; errs++;
            $display("FAIL tx_drain_timeout: %0d left required 0",
                     exp_tx.size());
            exp_tx.delete();
        end
        repeat (extra) tick();
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [7:0] a0,
                          input logic [7:0] a1, input bit stall);
        int hr0, cs0, ar0, tg0, sr0, p0, n, steps;
        logic [7:0] b;
        hr0 = hr_cnt; cs0 = cs_cnt; ar0 = ar_cnt;
        tg0 = tog_total; sr0 = step_rises; p0 = popped;
        steps = (op == 5) ? int'(a1) : 0;
        case (op)
            8'd0: exp_tx.push_back(8'(FW));
            8'd1: m_dead = a0;
            8'd2: m_fire = a0;
            8'd3: m_en = 1 - m_en;
            8'd5: begin m_sel = a0[2:0]; m_ud = a0[7]; end
            8'd6: m_off = (m_off + 1) % 8;
            8'd7: m_mode = a0[2:0];
            8'd10: begin
                for (int k = 0; k < 4; k++)
                    for (int j = 0; j < 4; j++) begin
                        b = hist[k*32 + 8*j +: 8];
                        exp_tx.push_back(b);
                    end
            end
            8'd14: begin exp_tx.push_back(8'(m_err)); m_err = 0; end
            default: ;
        endcase
        send_byte(op);
        if (nargs(op) > 0) send_byte(a0);
        if (nargs(op) > 1) send_byte(a1);
        if (stall) begin
            n = 0;
            while (popped - p0 < 4 && n < 2000) begin tick(); n++; end
            check("stall_reached", popped - p0, 4);
            force_busy = 1'b1;
            repeat (100) tick();
            force_busy = 1'b0;
        end
        drain(20 + steps * 8 * SH);
        check("hist_reset_cycles", hr_cnt - hr0, (op == 10) ? 1 : 0);
        check("clk_switch_cycles", cs_cnt - cs0, (op == 4) ? PL : 0);
        check("pll_areset_cycles", ar_cnt - ar0, (op == 13) ? PL : 0);
        check("scan_toggles", tog_total - tg0, steps * 8);
        check("step_count", step_rises - sr0, steps);
        check_regs();
    endtask

    task automatic do_timeout(input logic [7:0] op);
        send_byte(op);
        if (op == 5) send_byte(8'($urandom));
        repeat (RXTO + 10) tick();
        if (m_err < 255) m_err++;
        check_regs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] op, a0, a1;
        int sel;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_regs();
        rst_n = 1'b1;

        do_cmd(8'd0, 8'd0, 8'd0, 1'b0);
        do_cmd(8'd1, 8'h2A, 8'd0, 1'b0);
        do_timeout(8'd1);
        do_cmd(8'd14, 8'd0, 8'd0, 1'b0);

        hist = {32'hDEADBEEF, 32'h0, 32'h0, 32'h11223344};
        do_cmd(8'd10, 8'd0, 8'd0, 1'b1);

        do_cmd(8'd5, 8'h83, 8'd3, 1'b0);
        do_cmd(8'd5, 8'h02, 8'd0, 1'b0);
        do_cmd(8'd4, 8'd0, 8'd0, 1'b0);
        do_cmd(8'd13, 8'd0, 8'd0, 1'b0);
        for (int i = 0; i < 8; i++) do_cmd(8'd6, 8'd0, 8'd0, 1'b0);
        do_cmd(8'hFF, 8'd0, 8'd0, 1'b0);

        do_cmd(8'd2, 8'h33, 8'd0, 1'b0);
        do_cmd(8'd3, 8'd0, 8'd0, 1'b0);
        send_byte(8'd13);
        repeat (3) tick();
        check("areset_mid_pulse", int'(pll_areset), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        exp_tx.delete();
        check_regs();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 260; i++) do_timeout(8'd7);
        do_cmd(8'd14, 8'd0, 8'd0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 12);
            a0 = 8'($urandom);
            a1 = 8'($urandom_range(0, 2));
            case (sel)
                0: op = 8'd0;  1: op = 8'd1;  2: op = 8'd2;
                3: op = 8'd3;  4: op = 8'd4;  5: op = 8'd5;
                6: op = 8'd6;  7: op = 8'd7;  8: op = 8'd10;
                9: op = 8'd13; 10: op = 8'd14;
                default: begin
                    op = 8'($urandom);
                    while (is_valid(op)) op = 8'($urandom);
                end
            endcase
            if (op == 8'd10)
                hist = {$urandom, $urandom, $urandom, $urandom};
            if (sel == 12 && i % 2 == 0)
                do_timeout((i % 4 == 0) ? 8'd5 : 8'd2);
            else
                do_cmd(op, a0, a1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
